dll_code_ctrl: RTL and testbench

Delay-code controller for the FMDLL loop. It is the consumer of the phase detector's `COMP` decision and drives the 10-bit delay-line code `Q`, the look-ahead code `Q_next`, and the `M_counter`/`N_counter` window sequence that the phase detector uses. It runs a 10-step successive-approximation (SAR) search, then switches to ±1 tracking with lock detection.

---
 rtl/fmdll_pkg.sv | 38 +++
 rtl/dll_window_cnt.sv | 56 +++++
 rtl/dll_code_ctrl.sv | 134 +++++++++++++
 tb/tb_dll_code_ctrl.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/fmdll_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : fmdll_pkg
//  Purpose  : Shared constants, state encoding and helper functions for the
//             FMDLL delay-code controller and its window counter.
//  Revision : 1.0  initial release
// ============================================================================
package fmdll_pkg;

    localparam int             QW       = 10;
    localparam int             BW       = 4;      // width of the SAR bit index
    localparam logic [QW-1:0]  SAR_INIT = 10'd512;
    localparam logic [QW-1:0]  Q_MAX    = 10'd1023;

    typedef enum logic [0:0] {
        ST_SAR   = 1'b0,
        ST_TRACK = 1'b1
    } state_t;

    // Window count clamp: a programmed 0 behaves as 1.
    function automatic logic [3:0] win_eff(input logic [3:0] v);
        return (v == 4'd0) ? 4'd1 : v;
    endfunction

    function automatic logic [QW-1:0] onehot(input logic [BW-1:0] idx);
        return {{(QW-1){1'b0}}, 1'b1} << idx;
    endfunction

    function automatic logic [QW-1:0] sat_inc(input logic [QW-1:0] v);
        return (v == Q_MAX) ? v : v + {{(QW-1){1'b0}}, 1'b1};
    endfunction

    function automatic logic [QW-1:0] sat_dec(input logic [QW-1:0] v);
        return (v == '0) ? v : v - {{(QW-1){1'b0}}, 1'b1};
    endfunction

endpackage
`default_nettype wire

// File: rtl/dll_window_cnt.sv
`default_nettype none
// ============================================================================
//  Module   : dll_window_cnt
//  Purpose  : Nested M/N measurement-window counters for the FMDLL loop.
//  Ports    : clk, rst        - clock, synchronous active-high reset
//             m, n            - programmed outer/inner counts (0 acts as 1)
//             m_cnt, n_cnt    - counters, ranges 1..M_eff and 1..N_eff
//             win_end         - last cycle of a window (combinational)
//             eval            - registered strobe, one cycle after win_end
//  Revision : 1.0  initial release
// ============================================================================
module dll_window_cnt
    import fmdll_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] m,
    input  logic [3:0] n,
    output logic [1:0] m_cnt,
    output logic [3:0] n_cnt,
    output logic       win_end,
    output logic       eval
);

    logic [3:0] m_eff;
    logic [3:0] n_eff;
    logic [3:0] m_cnt_x;
    logic       n_wrap;

    assign m_eff   = win_eff({2'b00, m});
    assign n_eff   = win_eff(n);
    assign m_cnt_x = {2'b00, m_cnt};

    // ">=" rather than "==" so a counter left above a newly lowered limit
    // wraps to 1 on the very next cycle.
    assign n_wrap  = (n_cnt >= n_eff);
    assign win_end = (m_cnt_x == m_eff) && (n_cnt == n_eff);

    always_ff @(posedge clk) begin
        if (rst) begin
            m_cnt <= 2'd1;
            n_cnt <= 4'd1;
            eval  <= 1'b0;
        end else begin
            n_cnt <= n_wrap ? 4'd1 : n_cnt + 4'd1;
            if (m_cnt_x > m_eff) begin
                m_cnt <= 2'd1;
            end else if (n_wrap) begin
                m_cnt <= (m_cnt_x >= m_eff) ? 2'd1 : m_cnt + 2'd1;
            end
            eval <= win_end;
        end
    end

endmodule
`default_nettype wire

// File: rtl/dll_code_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : dll_code_ctrl
//  Purpose  : FMDLL delay-code controller. 10-step SAR search on the phase
//             detector decision, then +/-1 tracking with lock detection.
//  Ports    : clk_ext, Reset_CTRL - clock, synchronous active-high reset
//             M, N                - window counts (0 acts as 1)
//             COMP                - registered PD decision (1 = increase)
//             M_counter, N_counter- window counters for the PD
//             Q, Q_next           - applied code, code applied on COMP=1
//             sar_done, lock      - tracking entered, tracking locked
//  Revision : 1.0  initial release
// ============================================================================
module dll_code_ctrl #(
    parameter int              QW       = 10,
    parameter logic [QW-1:0]   SAR_INIT = 10'd512
) (
    input  logic          clk_ext,
    input  logic          Reset_CTRL,
    input  logic [1:0]    M,
    input  logic [3:0]    N,
    input  logic          COMP,
    output logic [1:0]    M_counter,
    output logic [3:0]    N_counter,
    output logic [QW-1:0] Q,
    output logic [QW-1:0] Q_next,
    output logic          sar_done,
    output logic          lock
);
    import fmdll_pkg::*;

    logic          eval;
    logic          win_end_unused;   // eval already carries the window timing

    state_t        state;
    logic [3:0]    bit_idx;
    logic          settle;           // discard the next eval (Q just moved)
    logic          hist_valid;
    logic          prev_dec;
    logic [2:0]    alt_cnt;          // length of current alternating run, sat 4

    logic [QW-1:0] sar_trial;
    logic [QW-1:0] sar_q_d;
    logic [QW-1:0] sar_qn_d;
    logic [QW-1:0] trk_q_d;
    logic [QW-1:0] trk_qn_d;

    dll_window_cnt u_win (
        .clk     (clk_ext),
        .rst     (Reset_CTRL),
        .m       (M),
        .n       (N),
        .m_cnt   (M_counter),
        .n_cnt   (N_counter),
        .win_end (win_end_unused),
        .eval    (eval)
    );

    // Next code / look-ahead for both modes. Q_next is registered together
    // with Q, so it is derived from the code that Q is about to take.
    always_comb begin
        sar_trial = COMP ? Q : (Q & ~onehot(bit_idx));
        sar_q_d   = (bit_idx != 4'd0) ? (sar_trial | onehot(bit_idx - 4'd1)) : sar_trial;
        if (bit_idx >= 4'd2) begin
            sar_qn_d = sar_q_d | onehot(bit_idx - 4'd2);
        end else if (bit_idx == 4'd1) begin
            sar_qn_d = sar_q_d;              // last bit pending: PD frozen
        end else begin
            sar_qn_d = sat_inc(sar_q_d);     // entering tracking
        end
        trk_q_d  = COMP ? sat_inc(Q) : sat_dec(Q);
        trk_qn_d = sat_inc(trk_q_d);
    end

    always_ff @(posedge clk_ext) begin
        if (Reset_CTRL) begin
            state      <= ST_SAR;
            bit_idx    <= 4'd9;
            settle     <= 1'b1;
            Q          <= SAR_INIT;
            Q_next     <= SAR_INIT | (SAR_INIT >> 1);
            sar_done   <= 1'b0;
            lock       <= 1'b0;
            hist_valid <= 1'b0;
            prev_dec   <= 1'b0;
            alt_cnt    <= 3'd0;
        end else if (eval) begin
            if (settle) begin
                settle <= 1'b0;
            end else begin
                case (state)
                    ST_SAR: begin
                        Q      <= sar_q_d;
                        Q_next <= sar_qn_d;
                        settle <= (sar_q_d != Q);
                        if (bit_idx == 4'd0) begin
                            state      <= ST_TRACK;
                            sar_done   <= 1'b1;
                            hist_valid <= 1'b0;
                            alt_cnt    <= 3'd0;
                            lock       <= 1'b0;
                        end else begin
                            bit_idx <= bit_idx - 4'd1;
                        end
                    end
                    ST_TRACK: begin
                        Q      <= trk_q_d;
                        Q_next <= trk_qn_d;
                        // A saturated step leaves Q alone and needs no settle.
                        settle <= (trk_q_d != Q);
                        prev_dec <= COMP;
                        if (!hist_valid) begin
                            hist_valid <= 1'b1;
                            alt_cnt    <= 3'd1;
                        end else if (COMP != prev_dec) begin
                            if (alt_cnt >= 3'd3) begin
                                lock <= 1'b1;
                            end
                            if (alt_cnt < 3'd4) begin
                                alt_cnt <= alt_cnt + 3'd1;
                            end
                        end else begin
                            alt_cnt <= 3'd1;
                            lock    <= 1'b0;
                        end
                    end
                    default: state <= ST_SAR;
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dll_code_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dll_code_ctrl
//  Purpose  : Directed self-checking bench for dll_code_ctrl.
//  Revision : 1.0  initial release
// ============================================================================
module tb_dll_code_ctrl;

    logic       clk_ext = 1'b0;
    logic       Reset_CTRL;
    logic [1:0] M;
    logic [3:0] N;
    logic       COMP;
    logic [1:0] M_counter;
    logic [3:0] N_counter;
    logic [9:0] Q;
    logic [9:0] Q_next;
    logic       sar_done;
    logic       lock;

    int checks = 0;
    int passed = 0;

    typedef struct {
        logic [9:0] q;
        logic [9:0] qn;
        logic       done;
    } sar_vec_t;

    typedef struct {
        logic [1:0] m;
        logic [3:0] n;
    } cnt_vec_t;

    sar_vec_t sar_tab [10];
    cnt_vec_t cnt_tab [6];

    dll_code_ctrl dut (
        .clk_ext    (clk_ext),
        .Reset_CTRL (Reset_CTRL),
        .M          (M),
        .N          (N),
        .COMP       (COMP),
        .M_counter  (M_counter),
        .N_counter  (N_counter),
        .Q          (Q),
        .Q_next     (Q_next),
        .sar_done   (sar_done),
        .lock       (lock)
    );

    always #5 clk_ext = ~clk_ext;

    task automatic step();
        @(posedge clk_ext);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic do_reset();
        Reset_CTRL = 1'b1;
        step();
        step();
        Reset_CTRL = 1'b0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_Q"},      int'(Q), 512);
        chk({tag, "_Qnext"},  int'(Q_next), 768);
        chk({tag, "_Mcnt"},   int'(M_counter), 1);
        chk({tag, "_Ncnt"},   int'(N_counter), 1);
        chk({tag, "_done"},   int'(sar_done), 0);
        chk({tag, "_lock"},   int'(lock), 0);
    endtask

    // M=N=1. Behavioural PD: COMP=1 while Q < target. One idle edge after
    // reset, then ten (settle, decision) edge pairs.
    task automatic run_sar(input int target, input bit use_tab, input string tag);
        logic [9:0] q_prev;
        step();
        chk({tag, "_idle_e1"}, int'(Q), 512);
        for (int k = 0; k < 10; k++) begin
            q_prev = Q;
            COMP = (int'(Q) < target);
            step();
            chk({tag, "_settle_hold"}, int'(Q), int'(q_prev));
            COMP = (int'(Q) < target);
            step();
            if (use_tab) begin
                chk({tag, "_sar_Q"},     int'(Q),        int'(sar_tab[k].q));
                chk({tag, "_sar_Qnext"}, int'(Q_next),   int'(sar_tab[k].qn));
                chk({tag, "_sar_done"},  int'(sar_done), int'(sar_tab[k].done));
            end
        end
    endtask

    initial begin
        logic [9:0] tq [4];
        logic       tl [4];

        // Target 701: largest accepted code is 700; bits 1,0,1,0,1,1,1,1,0,0.
        sar_tab[0] = '{10'd768, 10'd896, 1'b0};
        sar_tab[1] = '{10'd640, 10'd704, 1'b0};
        sar_tab[2] = '{10'd704, 10'd736, 1'b0};
        sar_tab[3] = '{10'd672, 10'd688, 1'b0};
        sar_tab[4] = '{10'd688, 10'd696, 1'b0};
        sar_tab[5] = '{10'd696, 10'd700, 1'b0};
        sar_tab[6] = '{10'd700, 10'd702, 1'b0};
        sar_tab[7] = '{10'd702, 10'd703, 1'b0};
        sar_tab[8] = '{10'd701, 10'd701, 1'b0};
        sar_tab[9] = '{10'd700, 10'd701, 1'b1};

        // M=2, N=3 counter sequence after edges 1..6.
        cnt_tab[0] = '{2'd1, 4'd2};
        cnt_tab[1] = '{2'd1, 4'd3};
        cnt_tab[2] = '{2'd2, 4'd1};
        cnt_tab[3] = '{2'd2, 4'd2};
        cnt_tab[4] = '{2'd2, 4'd3};
        cnt_tab[5] = '{2'd1, 4'd1};

        // ---------------- window counters, M=2 N=3 ----------------
        M = 2'd2; N = 4'd3; COMP = 1'b0;
        do_reset();
        chk_reset_vals("rst0");
        for (int i = 0; i < 6; i++) begin
            step();
            chk("cnt_M", int'(M_counter), int'(cnt_tab[i].m));
            chk("cnt_N", int'(N_counter), int'(cnt_tab[i].n));
        end
        // eval at cycle 6 is the settle discard; eval at cycle 12 decides.
        for (int i = 7; i <= 12; i++) step();
        chk("win_eval_hold", int'(Q), 512);
        step();
        chk("win_eval_Q", int'(Q), 256);
        chk("win_eval_Qnext", int'(Q_next), 384);
        step(); step(); step();                  // edge 16: N=2, M=2
        chk("clamp_pre_M", int'(M_counter), 2);
        M = 2'd0; N = 4'd0;
        step();
        chk("clamp_M", int'(M_counter), 1);
        chk("clamp_N", int'(N_counter), 1);
        step();
        chk("clamp_N_hold", int'(N_counter), 1);

        // ---------------- SAR to 700, then tracking/lock ----------------
        M = 2'd1; N = 4'd1;
        do_reset();
        chk_reset_vals("rst1");
        run_sar(701, 1'b1, "s700");

        tq[0] = 10'd701; tq[1] = 10'd700; tq[2] = 10'd701; tq[3] = 10'd700;
        tl[0] = 1'b0;    tl[1] = 1'b0;    tl[2] = 1'b0;    tl[3] = 1'b1;
        for (int k = 0; k < 4; k++) begin
            COMP = (int'(Q) < 701);
            step();
            COMP = (int'(Q) < 701);
            step();
            chk("trk_Q",     int'(Q),      int'(tq[k]));
            chk("trk_Qnext", int'(Q_next), int'(tq[k]) + 1);
            chk("trk_lock",  int'(lock),   int'(tl[k]));
        end
        COMP = 1'b0;
        step(); step();
        chk("unlock_D1_Q", int'(Q), 699);
        step(); step();
        chk("unlock_D2_Q", int'(Q), 698);
        chk("unlock_lock", int'(lock), 0);

        // Settle discard: Q just moved, so this COMP=0 pulse is ignored.
        COMP = 1'b0;
        step();
        chk("settle_discard_Q", int'(Q), 698);
        COMP = 1'b1;
        step();
        chk("settle_honour_Q", int'(Q), 699);

        // ---------------- saturation at the top ----------------
        do_reset();
        run_sar(1023, 1'b0, "s1023");
        chk("sat_sar_Q", int'(Q), 1022);
        chk("sat_sar_Qnext", int'(Q_next), 1023);
        chk("sat_sar_done", int'(sar_done), 1);
        COMP = 1'b1;
        step();
        chk("sat_settle_Q", int'(Q), 1022);
        step();
        chk("sat_Q", int'(Q), 1023);
        chk("sat_Qnext", int'(Q_next), 1023);
        step(); step(); step();
        chk("sat_hold_Q", int'(Q), 1023);
        chk("sat_hold_Qnext", int'(Q_next), 1023);
        chk("sat_lock", int'(lock), 0);
        // Saturated steps armed no settle, so this decision lands at once.
        COMP = 1'b0;
        step();
        chk("sat_nosettle_Q", int'(Q), 1022);
        chk("sat_nosettle_lock", int'(lock), 0);

        // ---------------- reset in the middle of SAR ----------------
        do_reset();
        step();
        for (int k = 0; k < 5; k++) begin
            COMP = (int'(Q) < 701);
            step();
            COMP = (int'(Q) < 701);
            step();
        end
        chk("mid_b4_Q", int'(Q), 688);
        Reset_CTRL = 1'b1;
        COMP = 1'b1;
        step();
        chk_reset_vals("rst_mid");
        Reset_CTRL = 1'b0;
        run_sar(701, 1'b1, "rerun");
        chk("rerun_done", int'(sar_done), 1);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
`default_nettype wire
